// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: redirect, instruction-memory request/response and decode hand-off.
// The master modport is the fetch unit side; slave is the core/memory environment.
interface instr_fetch_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            inst_valid;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    logic            inst_ready;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: credit-limited word fetch, in-order instruction buffer, redirect/drain.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module instr_fetch_unit #(
    parameter int unsigned          XLEN      = 32,
    parameter logic [XLEN-1:0]      RESET_PC  = 32'h0000_0000,
    parameter int unsigned          BUF_DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    instr_fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t          state;
    logic [XLEN-1:0] fetch_pc;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop;
    logic [CNT_W-1:0] buf_count;
    logic [PTR_W-1:0] buf_head;
    logic [PTR_W-1:0] buf_tail;
    logic [PTR_W-1:0] pq_head;
    logic [PTR_W-1:0] pq_tail;
    logic [XLEN-1:0] buf_pc   [BUF_DEPTH];
    logic [XLEN-1:0] buf_data [BUF_DEPTH];
    logic [XLEN-1:0] pq_pc    [BUF_DEPTH];

    logic             req_valid_c;
    logic             accept_c;
    logic             rsp_c;
    logic             push_c;
    logic             pop_c;
    logic [CNT_W-1:0] occupancy_c;
    logic [CNT_W-1:0] drop_calc_c;

    // Credit: buffered plus in-flight may never exceed the buffer depth.
    assign occupancy_c = buf_count + outstanding;
    assign req_valid_c = !rst && (state == RUN) && !bus.redirect_valid
                         && (occupancy_c < CNT_W'(BUF_DEPTH));
    assign accept_c    = req_valid_c && bus.imem_req_ready;
    assign rsp_c       = bus.imem_rsp_valid;
    assign push_c      = rsp_c && (state == RUN) && !bus.redirect_valid;
    assign pop_c       = (buf_count != '0) && bus.inst_ready && !bus.redirect_valid;
    assign drop_calc_c = outstanding + CNT_W'(accept_c) - CNT_W'(rsp_c);

    assign bus.imem_req_valid = req_valid_c;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.inst_valid     = (buf_count != '0);
    assign bus.inst_data      = buf_data[buf_head];
    assign bus.inst_pc        = buf_pc[buf_head];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            buf_count   <= '0;
            buf_head    <= '0;
            buf_tail    <= '0;
            pq_head     <= '0;
            pq_tail     <= '0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                buf_pc[i]   <= '0;
                buf_data[i] <= '0;
                pq_pc[i]    <= '0;
            end
        end else begin
            outstanding <= drop_calc_c;

            // PC queue tracks every accepted request, consumed by every response (kept or dropped).
            if (accept_c) begin
                pq_pc[pq_tail] <= fetch_pc;
                pq_tail        <= pq_tail + PTR_W'(1);
            end
            if (rsp_c) begin
                pq_head <= pq_head + PTR_W'(1);
            end
            if (push_c) begin
                buf_pc[buf_tail]   <= pq_pc[pq_head];
                buf_data[buf_tail] <= bus.imem_rsp_data;
            end

            if (bus.redirect_valid) begin
                fetch_pc  <= bus.redirect_pc & ~XLEN'(3);
                buf_head  <= '0;
                buf_tail  <= '0;
                buf_count <= '0;
                drop      <= drop_calc_c;
                state     <= (drop_calc_c != '0) ? DRAIN : RUN;
            end else begin
                if (accept_c) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (push_c) begin
                    buf_tail <= buf_tail + PTR_W'(1);
                end
                if (pop_c) begin
                    buf_head <= buf_head + PTR_W'(1);
                end
                buf_count <= buf_count + CNT_W'(push_c) - CNT_W'(pop_c);
                if ((state == DRAIN) && rsp_c) begin
                    drop <= drop - CNT_W'(1);
                    if (drop == CNT_W'(1)) begin
                        state <= RUN;
                    end
                end
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst)
                     !(push_c && !pop_c && (buf_count == CNT_W'(BUF_DEPTH))))
        else $error("instruction buffer overflow");

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (pop_c) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (req_valid_c && !bus.imem_req_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: in-order memory model, epoch-tagged stale tracking,
// per-cycle comparison against a queue-based model plus directed literal checks.
module tb_instr_fetch_unit;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned BUF_DEPTH = 2;
    localparam logic [31:0] RESET_PC  = 32'h0000_0100;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          rdy;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.XLEN(XLEN)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    instr_fetch_unit #(
        .XLEN(XLEN),
        .RESET_PC(RESET_PC),
        .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched)
        , .perf_stall(perf_stall)
`endif
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    req_t        mem_q[$];
    ent_t        buf_q[$];
    logic [31:0] req_log[$];
    logic [31:0] pop_log[$];
    int          epoch = 0;
    int          cyc = 0;
    logic [31:0] exp_fetch = RESET_PC;
    logic [31:0] m_fetched = 0;
    logic [31:0] m_stall = 0;

    int unsigned pr_ready  = 100;
    int unsigned pr_rsp    = 100;
    int unsigned pr_iready = 100;
    int unsigned pr_redir  = 0;
    int unsigned max_lat   = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.inst_ready     = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_req_addr", bus.imem_req_addr, RESET_PC);
        chk("rst_inst_data", bus.inst_data, 32'd0);
        chk("rst_inst_pc", bus.inst_pc, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf_fetched", perf_fetched, 32'd0);
        chk("rst_perf_stall", perf_stall, 32'd0);
`endif
        mem_q.delete();
        buf_q.delete();
        req_log.delete();
        pop_log.delete();
        exp_fetch = RESET_PC;
        m_fetched = 0;
        m_stall   = 0;
    endtask

    // One clock: drive inputs at negedge, compare against the model, then advance the model.
    task automatic step(input bit fr, input logic [31:0] fpc);
        bit   rdy, go, ir, rd, exp_rv, acc;
        int   stale;
        req_t r;
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        rdy = ($urandom_range(99) < pr_ready);
        go  = (mem_q.size() != 0) && (mem_q[0].rdy <= cyc) && ($urandom_range(99) < pr_rsp);
        ir  = ($urandom_range(99) < pr_iready);
        rd  = fr || ($urandom_range(999) < pr_redir);
        bus.imem_req_ready = rdy;
        bus.imem_rsp_valid = go;
        bus.imem_rsp_data  = go ? mem_word(mem_q[0].addr) : $urandom;
        bus.inst_ready     = ir;
        bus.redirect_valid = rd;
        bus.redirect_pc    = fr ? fpc : $urandom;
        #1;
        stale = 0;
        foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
        exp_rv = !rd && (stale == 0) && (buf_q.size() + mem_q.size() < BUF_DEPTH);
        chk("imem_req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
        if (exp_rv) chk("imem_req_addr", bus.imem_req_addr, exp_fetch);
        chk("inst_valid", 32'(bus.inst_valid), 32'(buf_q.size() != 0));
        if (buf_q.size() != 0) begin
            chk("inst_pc", bus.inst_pc, buf_q[0].pc);
            chk("inst_data", bus.inst_data, buf_q[0].data);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_stall", perf_stall, m_stall);
`endif
        acc = exp_rv && rdy;
        if (exp_rv && !rdy) m_stall++;
        if ((buf_q.size() != 0) && ir && !rd) begin
            pop_log.push_back(buf_q[0].pc);
            void'(buf_q.pop_front());
            m_fetched++;
        end
        if (go) begin
            r = mem_q.pop_front();
            if ((r.epoch == epoch) && !rd) buf_q.push_back('{pc: r.addr, data: mem_word(r.addr)});
        end
        if (acc) begin
            mem_q.push_back('{addr: exp_fetch, epoch: epoch, rdy: cyc + int'($urandom_range(max_lat, 1))});
            req_log.push_back(exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
        end
        if (rd) begin
            epoch++;
            buf_q.delete();
            exp_fetch = (fr ? fpc : bus.redirect_pc) & ~32'd3;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0);
    endtask

    task automatic set_knobs(input int unsigned rq, input int unsigned rs, input int unsigned ir,
                             input int unsigned rd, input int unsigned lat);
        pr_ready = rq; pr_rsp = rs; pr_iready = ir; pr_redir = rd; max_lat = lat;
    endtask

    initial begin
        int np, nr;
        idle_inputs();

        // Streaming from reset with an always-ready, 1-cycle memory.
        do_reset();
        set_knobs(100, 100, 100, 0, 1);
        run(20);
        chk("stream_pc0", qget(pop_log, 0), 32'h0000_0100);
        chk("stream_pc1", qget(pop_log, 1), 32'h0000_0104);
        chk("stream_pc2", qget(pop_log, 2), 32'h0000_0108);
        chk("stream_cnt_ge12", 32'(pop_log.size() >= 12), 32'd1);
        chk("mem_word_0x100", mem_word(32'h100), 32'h5A5A_0100);

        // Decode stalled: buffer fills with 0x100/0x104 and fetch stops.
        do_reset();
        set_knobs(100, 100, 0, 0, 1);
        run(6);
        @(posedge clk);
        #1;
        chk("full_head_pc", bus.inst_pc, 32'h0000_0100);
        chk("full_head_data", bus.inst_data, 32'h5A5A_0100);
        chk("full_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("full_req_count", 32'(req_log.size()), 32'd2);
        pr_iready = 100;
        run(8);
        chk("drain_pc0", qget(pop_log, 0), 32'h0000_0100);
        chk("drain_pc1", qget(pop_log, 1), 32'h0000_0104);
        chk("resume_req", qget(req_log, 2), 32'h0000_0108);

        // Memory not ready for 5 cycles: address held, stall counted.
        do_reset();
        set_knobs(0, 100, 100, 0, 1);
        run(5);
        @(posedge clk);
        #1;
        chk("stall_addr", bus.imem_req_addr, 32'h0000_0100);
        chk("stall_no_accept", 32'(req_log.size()), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("stall_perf5", perf_stall, 32'd5);
`endif

        // Redirect to 0x203 with two requests in flight.
        do_reset();
        set_knobs(100, 0, 0, 0, 1);
        run(2);
        chk("pre_redir_out", 32'(mem_q.size()), 32'd2);
        step(1'b1, 32'h0000_0203);
        set_knobs(100, 100, 100, 0, 1);
        run(10);
        chk("redir_req0", qget(req_log, 2), 32'h0000_0200);
        chk("redir_pop0", qget(pop_log, 0), 32'h0000_0200);

        // Redirect in the same cycle as a response arrival.
        do_reset();
        set_knobs(100, 100, 100, 0, 1);
        run(4);
        np = pop_log.size();
        step(1'b1, 32'h0000_0400);
        run(8);
        chk("redir_rsp_pop0", qget(pop_log, np), 32'h0000_0400);

        // Fetch PC wraps past the top of the address space.
        nr = req_log.size();
        step(1'b1, 32'hFFFF_FFFE);
        run(8);
        chk("wrap_req0", qget(req_log, nr), 32'hFFFF_FFFC);
        chk("wrap_req1", qget(req_log, nr + 1), 32'h0000_0000);

        // Randomized traffic with occasional mid-run reset.
        for (int blk = 0; blk < 15; blk++) begin
            set_knobs($urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(100, 0),
                      $urandom_range(30, 0), $urandom_range(4, 1));
            if (blk == 7) do_reset();
            run(200);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
